instr_mem_loader: RTL and testbench

Byte-stream program loader that writes 32-bit instructions into the instruction memory read by the fetch stage. It is the writing end of the PC → Instruction_Memory_ROM fetch path, and replaces the bench-only file preload with synthesizable hardware. While it loads, it holds the pipeline by deasserting the PC and IF/ID enables. It accepts a framed stream (count, data, checksum), assembles big-endian words, writes them at byte addresses 0, 4, 8, …, and then releases the CPU.

---
 rtl/instr_mem_loader.sv | 122 ++++++++++++
 tb/tb_instr_mem_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: takes a framed stream (count, big-endian words, XOR checksum),
// writes each word to instruction memory at consecutive word addresses and holds the CPU until done.
module instr_mem_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  total_q, total_d;
    logic [6:0]  word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        accept;
    logic        restart;

    assign accept  = byte_valid && byte_ready;
    assign restart = load_start &&
                     (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            total_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            acc_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            acc_q      <= acc_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (load_start) state_d = S_COUNT;
            S_COUNT: begin
                if (accept) state_d = (byte_data > 8'd64) ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                if (accept && byte_idx_q == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: state_d = (word_idx_q + 7'd1 == total_q) ? S_CHECK : S_DATA;
            S_CHECK: begin
                if (accept) state_d = (byte_data == acc_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: word assembly, running XOR checksum and write address capture
    always_comb begin
        total_d    = total_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        acc_d      = acc_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        if (restart) begin
            word_idx_d = '0;
            byte_idx_d = '0;
            acc_d      = '0;
        end
        if (state_q == S_COUNT && accept) begin
            total_d = (byte_data == 8'd0) ? 7'd64 : byte_data[6:0];
            acc_d   = acc_q ^ byte_data;
        end
        if (state_q == S_DATA && accept) begin
            unique case (byte_idx_q)
                2'd0: wdata_d[31:24] = byte_data;
                2'd1: wdata_d[23:16] = byte_data;
                2'd2: wdata_d[15:8]  = byte_data;
                default: wdata_d[7:0] = byte_data;
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
            acc_d      = acc_q ^ byte_data;
            if (byte_idx_q == 2'd3) addr_d = {word_idx_q[5:0], 2'b00};
        end
        if (state_q == S_WRITE) word_idx_d = word_idx_q + 7'd1;
        done_d = (state_q == S_CHECK) && accept && (byte_data == acc_q);
    end

    // Outputs are decodes of registered state, so the WRITE cycle never offers byte_ready
    always_comb begin
        byte_ready = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
        mem_we     = (state_q == S_WRITE);
        cpu_hold   = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_WRITE) ||
                     (state_q == S_CHECK) || (state_q == S_ERROR);
        load_error = (state_q == S_ERROR);
        load_done  = done_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table of single-word frames plus
// hand-written full-image, backpressure, illegal-count and mid-load reset sequences.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    instr_mem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int hold_at_done = 0;
    int we_ready_viol = 0;
    int first_cyc = 0;
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  stream[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (byte_ready) we_ready_viol <= we_ready_viol + 1;
        end
        if (load_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            if (cpu_hold) hold_at_done <= hold_at_done + 1;
        end
    end

    typedef struct packed {
        logic [47:0] frame;     // count, 4 data bytes, checksum
        logic [31:0] exp_data;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        byte_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout: byte %0h not accepted within 20 cycles", b);
        end
    endtask

    task automatic play_stream();
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i]);
            if (i == 0) first_cyc = cyc;
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic check_idle_outputs_zero(input string tag);
        chk({tag, "_byte_ready"}, byte_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_load_done"}, load_done, 0);
        chk({tag, "_load_error"}, load_error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, dbase, vbase;
        logic [7:0] acc;
        logic [31:0] w;

        vecs[0] = '{frame: 48'h01E3A0100557, exp_data: 32'hE3A01005, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{frame: 48'h011122334445, exp_data: 32'h11223344, exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{frame: 48'h01E3A0100500, exp_data: 32'hE3A01005, exp_done: 1'b0, exp_err: 1'b1};
        vecs[3] = '{frame: 48'h01FFFFFFFF01, exp_data: 32'hFFFFFFFF, exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{frame: 48'h010000000001, exp_data: 32'h00000000, exp_done: 1'b1, exp_err: 1'b0};

        reset = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (2) @(negedge clk);
        check_idle_outputs_zero("reset");
        reset = 1'b0;

        // Single-word frames; an error frame is followed by a good one to show recovery
        for (int i = 0; i < 5; i++) begin
            base  = wr_addr.size();
            dbase = done_cnt;
            start_load();
            chk("vec_hold_on_start", cpu_hold, 1);
            chk("vec_error_cleared", load_error, 0);
            stream = {};
            for (int j = 0; j < 6; j++) stream.push_back(vecs[i].frame[47 - 8*j -: 8]);
            play_stream();
            repeat (2) @(negedge clk);
            chk("vec_write_count", wr_addr.size() - base, 1);
            if (wr_addr.size() > base) begin
                chk("vec_addr", wr_addr[base], 8'h00);
                chk("vec_data", wr_data[base], vecs[i].exp_data);
            end
            chk("vec_done_count", done_cnt - dbase, {31'd0, vecs[i].exp_done});
            chk("vec_load_error", load_error, vecs[i].exp_err);
            chk("vec_cpu_hold", cpu_hold, vecs[i].exp_err);
            chk("vec_byte_ready_after", byte_ready, 0);
            if (vecs[i].exp_done) chk("vec_latency", done_cyc - first_cyc, 6);
        end

        // Illegal count goes straight to ERROR without writing
        base = wr_addr.size();
        start_load();
        stream = {8'h41};
        play_stream();
        repeat (2) @(negedge clk);
        chk("illegal_no_write", wr_addr.size() - base, 0);
        chk("illegal_error", load_error, 1);
        chk("illegal_byte_ready", byte_ready, 0);
        chk("illegal_hold", cpu_hold, 1);

        // Full 64-word image via count 0x00
        base  = wr_addr.size();
        dbase = done_cnt;
        stream = {8'h00};
        acc = 8'h00;
        for (int i = 0; i < 64; i++) begin
            w = {i[7:0], i[7:0] ^ 8'hA5, ~i[7:0], 8'h5A};
            for (int j = 0; j < 4; j++) stream.push_back(w[31 - 8*j -: 8]);
        end
        for (int i = 0; i < stream.size(); i++) acc ^= stream[i];
        stream.push_back(acc);
        start_load();
        play_stream();
        repeat (2) @(negedge clk);
        chk("full_write_count", wr_addr.size() - base, 64);
        if (wr_addr.size() - base == 64) begin
            for (int i = 0; i < 64; i++) begin
                w = {i[7:0], i[7:0] ^ 8'hA5, ~i[7:0], 8'h5A};
                chk("full_addr", wr_addr[base + i], 4 * i);
                chk("full_data", wr_data[base + i], w);
            end
        end
        chk("full_done", done_cnt - dbase, 1);
        chk("full_latency", done_cyc - first_cyc, 321);
        chk("full_error", load_error, 0);
        chk("full_hold", cpu_hold, 0);

        // Two words with byte_valid kept high across WRITE cycles
        base  = wr_addr.size();
        dbase = done_cnt;
        vbase = we_ready_viol;
        stream = {8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        acc = 8'h00;
        for (int i = 0; i < stream.size(); i++) acc ^= stream[i];
        stream.push_back(acc);
        start_load();
        play_stream();
        repeat (2) @(negedge clk);
        chk("bp_write_count", wr_addr.size() - base, 2);
        if (wr_addr.size() - base == 2) begin
            chk("bp_addr0", wr_addr[base], 8'h00);
            chk("bp_data0", wr_data[base], 32'h11223344);
            chk("bp_addr1", wr_addr[base + 1], 8'h04);
            chk("bp_data1", wr_data[base + 1], 32'h55667788);
        end
        chk("bp_ready_low_in_write", we_ready_viol - vbase, 0);
        chk("bp_done", done_cnt - dbase, 1);
        chk("bp_latency", done_cyc - first_cyc, 11);

        // Asynchronous reset in the middle of a word
        start_load();
        stream = {8'h01, 8'hAA, 8'hBB};
        play_stream();
        chk("rst_hold_before", cpu_hold, 1);
        chk("rst_wdata_before", mem_wdata[31:16], 16'hAABB);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        base  = wr_addr.size();
        dbase = done_cnt;
        start_load();
        stream = {};
        for (int j = 0; j < 6; j++) stream.push_back(vecs[0].frame[47 - 8*j -: 8]);
        play_stream();
        repeat (2) @(negedge clk);
        chk("after_rst_write_count", wr_addr.size() - base, 1);
        if (wr_addr.size() > base) begin
            chk("after_rst_addr", wr_addr[base], 8'h00);
            chk("after_rst_data", wr_data[base], 32'hE3A01005);
        end
        chk("after_rst_done", done_cnt - dbase, 1);
        chk("hold_low_at_done", hold_at_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
